// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore FSM that drives every control input of the single-bus datapath.
//   It fetches an instruction (T0-T2), then executes one register/unary ALU
//   instruction (T3-T5) and loops straight back to fetch. Also handles the
//   memory-read wait handshake, HALT, NOP, illegal opcodes and a read timeout.
//
// Parameters
//   TIMEOUT  max T1 cycles spent waiting for mem_ready before FAULT (1..31)
//   HALT_OP  opcode that parks the sequencer in HALT
//   NOP_OP   opcode that returns to fetch with no execute steps
//
// Ports
//   clk          in   datapath clock, rising edge
//   clr          in   asynchronous active-low reset
//   run          in   start request, only looked at in IDLE
//   mem_ready    in   memory read data valid (only looked at in T1)
//   ir_data      in   IR contents: [31:27] opc, [26:23] Ra, [22:19] Rb, [18:15] Rc
//   pc_out, zlo_out, mdr_out            out  bus-drive selects
//   mar_enable, z_enable, pc_enable,
//   mdr_enable, ir_enable, y_enable     out  register load enables
//   pc_increment                        out  PC increment
//   read                                out  MDR input mux select (memory side)
//   r_out        out  one-hot GPR bus-drive select
//   r_enable     out  one-hot GPR load enable
//   op_code      out  ALU operation, zero outside T4
//   busy         out  high outside IDLE, HALT and FAULT
//   halted       out  high in HALT
//   fault        out  high in FAULT
//   illegal      out  high for the T3 cycle of an unsupported opcode

module control_sequencer #(
  parameter int         TIMEOUT = 16,
  parameter logic [4:0] HALT_OP = 5'b11011,
  parameter logic [4:0] NOP_OP  = 5'b11010
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir_data,
  output logic        pc_out,
  output logic        zlo_out,
  output logic        mdr_out,
  output logic        mar_enable,
  output logic        z_enable,
  output logic        pc_enable,
  output logic        mdr_enable,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        pc_increment,
  output logic        read,
  output logic [15:0] r_out,
  output logic [15:0] r_enable,
  output logic [4:0]  op_code,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT,
    S_FAULT
  } state_t;

  // The wait counter is only 5 bits wide, so the timeout limit is too.
  localparam logic [4:0] TIMEOUT_LIM = 5'(TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [4:0] wait_cnt;
  logic [4:0] wait_cnt_next;
  logic [4:0] wait_cnt_inc;

  logic [4:0] opc;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       is_binary;
  logic       is_unary;
  logic       unused_ir_bits;

  assign opc = ir_data[31:27];
  assign ra  = ir_data[26:23];
  assign rb  = ir_data[22:19];
  assign rc  = ir_data[18:15];

  // The low IR bits carry immediates for formats this sequencer never executes.
  assign unused_ir_bits = ^ir_data[14:0];

  // Binary ops take Rb through Y and Rc on the bus; unary ops use Rb only.
  assign is_binary = (opc >= 5'b00011) && (opc <= 5'b01011);
  assign is_unary  = (opc == 5'b10001) || (opc == 5'b10010);

  // A long stall must not wrap the counter back to small values.
  assign wait_cnt_inc = (wait_cnt == 5'h1F) ? wait_cnt : wait_cnt + 5'd1;

  // State register. Reset takes effect immediately, so every output (all
  // decoded from state) drops in the same cycle and no partial write lands.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory wait counter, counting T1 cycles of the current fetch.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_cnt <= 5'd0;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state logic. T1 only exits on mem_ready or once the counter shows
  // TIMEOUT cycles spent without data; HALT and FAULT are absorbing.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_next = S_T0;
        end
      end
      S_T0: begin
        state_next    = S_T1;
        wait_cnt_next = 5'd0;
      end
      S_T1: begin
        wait_cnt_next = wait_cnt_inc;
        if (mem_ready) begin
          state_next = S_T2;
        end else if (wait_cnt_inc >= TIMEOUT_LIM) begin
          state_next = S_FAULT;
        end
      end
      S_T2: begin
        state_next = S_T3;
      end
      S_T3: begin
        if (is_binary || is_unary) begin
          state_next = S_T4;
        end else if (opc == HALT_OP) begin
          state_next = S_HALT;
        end else begin
          state_next = S_T0;
        end
      end
      S_T4: begin
        state_next = S_T5;
      end
      S_T5: begin
        state_next = S_T0;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Moore output decode. Only one bus driver is ever selected per state.
  // The PC advances through pc_increment alone; no supported instruction
  // loads the PC from the bus, so pc_enable stays low.
  always_comb begin
    pc_out       = 1'b0;
    zlo_out      = 1'b0;
    mdr_out      = 1'b0;
    mar_enable   = 1'b0;
    z_enable     = 1'b0;
    pc_enable    = 1'b0;
    mdr_enable   = 1'b0;
    ir_enable    = 1'b0;
    y_enable     = 1'b0;
    pc_increment = 1'b0;
    read         = 1'b0;
    r_out        = 16'h0000;
    r_enable     = 16'h0000;
    op_code      = 5'b00000;
    busy         = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    illegal      = 1'b0;
    case (state)
      S_T0: begin
        busy         = 1'b1;
        pc_out       = 1'b1;
        mar_enable   = 1'b1;
        pc_increment = 1'b1;
      end
      S_T1: begin
        busy       = 1'b1;
        read       = 1'b1;
        mdr_enable = 1'b1;
      end
      S_T2: begin
        busy      = 1'b1;
        mdr_out   = 1'b1;
        ir_enable = 1'b1;
      end
      S_T3: begin
        busy = 1'b1;
        if (is_binary) begin
          r_out    = 16'h0001 << rb;
          y_enable = 1'b1;
        end else if (!is_unary && (opc != NOP_OP) && (opc != HALT_OP)) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        busy     = 1'b1;
        r_out    = is_binary ? (16'h0001 << rc) : (16'h0001 << rb);
        op_code  = opc;
        z_enable = 1'b1;
      end
      S_T5: begin
        busy     = 1'b1;
        zlo_out  = 1'b1;
        r_enable = 16'h0001 << ra;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed bench for control_sequencer. Each task walks the FSM through one
//   scenario and compares the control outputs against hand-derived values.
//   A background monitor checks bus-driver exclusivity and one-hot GPR selects
//   on every falling edge.

module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir_data;
  logic        pc_out, zlo_out, mdr_out;
  logic        mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable;
  logic        pc_increment, read;
  logic [15:0] r_out, r_enable;
  logic [4:0]  op_code;
  logic        busy, halted, fault, illegal;

  int errors = 0;
  int checks = 0;

  // Control vector order: pc_out zlo_out mdr_out mar_enable z_enable pc_enable
  // mdr_enable ir_enable y_enable pc_increment read
  logic [10:0] ctl;
  logic [3:0]  stat;
  assign ctl  = {pc_out, zlo_out, mdr_out, mar_enable, z_enable, pc_enable,
                 mdr_enable, ir_enable, y_enable, pc_increment, read};
  assign stat = {busy, halted, fault, illegal};

  localparam logic [10:0] C_NONE = 11'b000_0000_0000;
  localparam logic [10:0] C_T0   = 11'b100_1000_0010;
  localparam logic [10:0] C_T1   = 11'b000_0001_0001;
  localparam logic [10:0] C_T2   = 11'b001_0000_1000;
  localparam logic [10:0] C_T3B  = 11'b000_0000_0100;
  localparam logic [10:0] C_T4   = 11'b000_0100_0000;
  localparam logic [10:0] C_T5   = 11'b010_0000_0000;

  localparam logic [3:0] ST_IDLE  = 4'b0000;
  localparam logic [3:0] ST_BUSY  = 4'b1000;
  localparam logic [3:0] ST_ILL   = 4'b1001;
  localparam logic [3:0] ST_HALT  = 4'b0100;
  localparam logic [3:0] ST_FAULT = 4'b0010;

  // and R2,R2,R3 : opc 00101, Ra=2, Rb=2, Rc=3
  localparam logic [31:0] IR_AND  = {5'b00101, 4'd2, 4'd2, 4'd3, 15'd0};
  // not R5,R7 : opc 10010, Ra=5, Rb=7
  localparam logic [31:0] IR_NOT  = {5'b10010, 4'd5, 4'd7, 4'd0, 15'd0};
  localparam logic [31:0] IR_NOP  = {5'b11010, 27'd0};
  localparam logic [31:0] IR_HALT = {5'b11011, 27'd0};
  localparam logic [31:0] IR_ILL  = {5'b11111, 27'd0};

  control_sequencer #(
    .TIMEOUT(16),
    .HALT_OP(5'b11011),
    .NOP_OP (5'b11010)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .run         (run),
    .mem_ready   (mem_ready),
    .ir_data     (ir_data),
    .pc_out      (pc_out),
    .zlo_out     (zlo_out),
    .mdr_out     (mdr_out),
    .mar_enable  (mar_enable),
    .z_enable    (z_enable),
    .pc_enable   (pc_enable),
    .mdr_enable  (mdr_enable),
    .ir_enable   (ir_enable),
    .y_enable    (y_enable),
    .pc_increment(pc_increment),
    .read        (read),
    .r_out       (r_out),
    .r_enable    (r_enable),
    .op_code     (op_code),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants, sampled away from the active edge.
  always @(negedge clk) begin
    checks++;
    if ($countones({pc_out, zlo_out, mdr_out, |r_out}) > 1 ||
        !$onehot0(r_out) || !$onehot0(r_enable)) begin
      errors++;
      $display("[TB] FAIL bus_exclusive_onehot @%0t: drivers=%b r_out=%h r_enable=%h required exclusive/onehot0",
               $time, {pc_out, zlo_out, mdr_out}, r_out, r_enable);
    end
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr       = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    ir_data   = 32'h0;
    step();
    step();
    checks++;
    if (ctl !== C_NONE || stat !== ST_IDLE || r_out !== 16'h0 || r_enable !== 16'h0 || op_code !== 5'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ctl=%b stat=%b r_out=%h r_en=%h op=%b required all zero",
               ctl, stat, r_out, r_enable, op_code);
    end
    clr = 1'b1;
    step();
    step();
    checks++;
    if (ctl !== C_NONE || stat !== ST_IDLE) begin
      errors++;
      $display("[TB] FAIL idle_without_run: ctl=%b stat=%b required %b %b", ctl, stat, C_NONE, ST_IDLE);
    end
  endtask

  // Ready memory: T0..T5 in six cycles, then straight back to T0.
  task automatic test_alu_fetch();
    logic [10:0] e_ctl [7] = '{C_T0, C_T1, C_T2, C_T3B, C_T4, C_T5, C_T0};
    logic [15:0] e_ro  [7] = '{16'h0, 16'h0, 16'h0, 16'h0004, 16'h0008, 16'h0, 16'h0};
    logic [15:0] e_re  [7] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0004, 16'h0};
    logic [4:0]  e_op  [7] = '{5'h0, 5'h0, 5'h0, 5'h0, 5'b00101, 5'h0, 5'h0};
    ir_data   = IR_AND;
    mem_ready = 1'b1;
    run       = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      checks++;
      if (ctl !== e_ctl[i] || r_out !== e_ro[i] || r_enable !== e_re[i] ||
          op_code !== e_op[i] || stat !== ST_BUSY) begin
        errors++;
        $display("[TB] FAIL alu_and_cycle%0d: ctl=%b r_out=%h r_en=%h op=%b stat=%b required %b %h %h %b %b",
                 i, ctl, r_out, r_enable, op_code, stat, e_ctl[i], e_ro[i], e_re[i], e_op[i], ST_BUSY);
      end
    end
  endtask

  // Three not-ready cycles keep T1 for four cycles; then a NOP in 4 cycles.
  task automatic test_mem_wait();
    ir_data   = IR_NOP;
    mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (ctl !== C_T1 || stat !== ST_BUSY) begin
        errors++;
        $display("[TB] FAIL mem_wait_t1_cycle%0d: ctl=%b stat=%b required %b %b", i, ctl, stat, C_T1, ST_BUSY);
      end
    end
    mem_ready = 1'b1;
    step();
    checks++;
    if (ctl !== C_T2) begin
      errors++;
      $display("[TB] FAIL mem_wait_t2: ctl=%b required %b", ctl, C_T2);
    end
    step();
    checks++;
    if (ctl !== C_NONE || stat !== ST_BUSY || r_out !== 16'h0) begin
      errors++;
      $display("[TB] FAIL nop_t3: ctl=%b stat=%b r_out=%h required %b %b 0000", ctl, stat, r_out, C_NONE, ST_BUSY);
    end
    step();
    checks++;
    if (ctl !== C_T0 || stat !== ST_BUSY) begin
      errors++;
      $display("[TB] FAIL nop_back_to_t0: ctl=%b stat=%b required %b %b", ctl, stat, C_T0, ST_BUSY);
    end
  endtask

  // Unary op: no Y load in T3, Rb drives the bus in T4.
  task automatic test_unary();
    logic [10:0] e_ctl [6] = '{C_T0, C_T1, C_T2, C_NONE, C_T4, C_T5};
    logic [15:0] e_ro  [6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0080, 16'h0};
    logic [15:0] e_re  [6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0020};
    logic [4:0]  e_op  [6] = '{5'h0, 5'h0, 5'h0, 5'h0, 5'b10010, 5'h0};
    ir_data   = IR_NOT;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (ctl !== e_ctl[i] || r_out !== e_ro[i] || r_enable !== e_re[i] ||
          op_code !== e_op[i] || stat !== ST_BUSY) begin
        errors++;
        $display("[TB] FAIL unary_not_cycle%0d: ctl=%b r_out=%h r_en=%h op=%b stat=%b required %b %h %h %b %b",
                 i, ctl, r_out, r_enable, op_code, stat, e_ctl[i], e_ro[i], e_re[i], e_op[i], ST_BUSY);
      end
    end
    step();
  endtask

  // Illegal opcode pulses once and refetches; HALT then parks the FSM.
  task automatic test_illegal_halt();
    ir_data = IR_ILL;
    step();
    step();
    step();
    checks++;
    if (stat !== ST_ILL || ctl !== C_NONE || r_out !== 16'h0) begin
      errors++;
      $display("[TB] FAIL illegal_t3: stat=%b ctl=%b r_out=%h required %b %b 0000", stat, ctl, r_out, ST_ILL, C_NONE);
    end
    step();
    checks++;
    if (stat !== ST_BUSY || ctl !== C_T0) begin
      errors++;
      $display("[TB] FAIL illegal_to_t0: stat=%b ctl=%b required %b %b", stat, ctl, ST_BUSY, C_T0);
    end
    ir_data = IR_HALT;
    step();
    step();
    step();
    checks++;
    if (stat !== ST_BUSY || ctl !== C_NONE) begin
      errors++;
      $display("[TB] FAIL halt_t3: stat=%b ctl=%b required %b %b", stat, ctl, ST_BUSY, C_NONE);
    end
    step();
    checks++;
    if (stat !== ST_HALT || ctl !== C_NONE) begin
      errors++;
      $display("[TB] FAIL halt_enter: stat=%b ctl=%b required %b %b", stat, ctl, ST_HALT, C_NONE);
    end
    run = 1'b1;
    step();
    step();
    run = 1'b0;
    step();
    checks++;
    if (stat !== ST_HALT || ctl !== C_NONE) begin
      errors++;
      $display("[TB] FAIL halt_absorbing: stat=%b ctl=%b required %b %b", stat, ctl, ST_HALT, C_NONE);
    end
  endtask

  // Reset in the middle of T4 clears every output at once.
  task automatic test_clear_mid_t4();
    clr = 1'b0;
    #1;
    checks++;
    if (stat !== ST_IDLE || ctl !== C_NONE) begin
      errors++;
      $display("[TB] FAIL clr_leaves_halt: stat=%b ctl=%b required %b %b", stat, ctl, ST_IDLE, C_NONE);
    end
    step();
    clr       = 1'b1;
    ir_data   = IR_AND;
    mem_ready = 1'b1;
    run       = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    step();
    step();
    checks++;
    if (ctl !== C_T4 || op_code !== 5'b00101 || r_out !== 16'h0008) begin
      errors++;
      $display("[TB] FAIL clr_pre_t4: ctl=%b op=%b r_out=%h required %b 00101 0008", ctl, op_code, r_out, C_T4);
    end
    #3;
    clr = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE || r_out !== 16'h0 || r_enable !== 16'h0 || op_code !== 5'h0 || stat !== ST_IDLE) begin
      errors++;
      $display("[TB] FAIL clr_mid_t4: ctl=%b r_out=%h r_en=%h op=%b stat=%b required all zero",
               ctl, r_out, r_enable, op_code, stat);
    end
    step();
    clr = 1'b1;
    step();
    step();
    checks++;
    if (ctl !== C_NONE || stat !== ST_IDLE) begin
      errors++;
      $display("[TB] FAIL clr_idle_after_release: ctl=%b stat=%b required %b %b", ctl, stat, C_NONE, ST_IDLE);
    end
    run = 1'b1;
    step();
    run = 1'b0;
    checks++;
    if (ctl !== C_T0 || stat !== ST_BUSY) begin
      errors++;
      $display("[TB] FAIL clr_restart: ctl=%b stat=%b required %b %b", ctl, stat, C_T0, ST_BUSY);
    end
  endtask

  // Memory never answers: 16 T1 cycles, then FAULT, which ignores run.
  task automatic test_timeout();
    mem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (ctl !== C_T1 || stat !== ST_BUSY) begin
        errors++;
        $display("[TB] FAIL timeout_t1_cycle%0d: ctl=%b stat=%b required %b %b", i, ctl, stat, C_T1, ST_BUSY);
      end
    end
    step();
    checks++;
    if (stat !== ST_FAULT || ctl !== C_NONE || r_out !== 16'h0 || r_enable !== 16'h0 || op_code !== 5'h0) begin
      errors++;
      $display("[TB] FAIL timeout_fault: stat=%b ctl=%b r_out=%h r_en=%h op=%b required %b all-zero",
               stat, ctl, r_out, r_enable, op_code, ST_FAULT);
    end
    run = 1'b1;
    step();
    run       = 1'b0;
    mem_ready = 1'b1;
    step();
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    checks++;
    if (stat !== ST_FAULT || ctl !== C_NONE) begin
      errors++;
      $display("[TB] FAIL fault_absorbing: stat=%b ctl=%b required %b %b", stat, ctl, ST_FAULT, C_NONE);
    end
  endtask

  initial begin
    test_reset();
    test_alu_fetch();
    test_mem_wait();
    test_unary();
    test_illegal_halt();
    test_clear_mid_t4();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
